pio_button_poller: RTL
======================

# pio_button_poller

Avalon-MM master that periodically reads bit 0 of a single-bit input PIO slave (button port at register address 0, registered read data, fixed read latency 1) and turns the raw samples into a debounced button level, a one-cycle press pulse and a press counter. It sits between the system interconnect and control logic that needs button events without software polling. It is the initiator for the button PIO responders in the Qsys system, such as the up/down buttons.

## Interface
Parameters:
- POLL_DIV, 50000: clock cycles between poll ticks; must be ≥ 4.
- DEBOUNCE_SAMPLES, 4: consecutive identical samples required to change the level; range 2..15.
- ACTIVE_LOW, 1: 1 means raw bit 0 = pressed; 0 means raw bit 1 = pressed.

Ports:
- clk  in  1  system clock; the block uses this one clock only.
- reset  in  1  asynchronous, active-high reset.
- address  out  2  Avalon read address; constant 0.
- read  out  1  Avalon read request.
- waitrequest  in  1  slave stall; the read is accepted on a cycle with read=1 and waitrequest=0.
- readdata  in  32  slave data; only bit 0 is used.
- level  out  1  debounced pressed state (1 = pressed).
- press_pulse  out  1  one-cycle strobe on a released→pressed transition of level.
- press_count  out  8  number of presses, wraps 255→0.
- overrun  out  1  sticky; set when a poll tick arrives while a read is in flight.
- clear_overrun  in  1  synchronous clear of overrun.

## Operation
- Tick timer: down-counter loaded with POLL_DIV-1 at reset. It decrements every cycle. At 0 it emits a tick and reloads. It free-runs regardless of bus stalls.
- FSM states: IDLE, REQ, CAPTURE.
  - IDLE: on a tick, go to REQ.
  - REQ: read=1, held while waitrequest=1. On acceptance, go to CAPTURE.
  - CAPTURE: sample = readdata[0] XOR ACTIVE_LOW, registered. Go to IDLE.
- A tick in REQ or CAPTURE is dropped and overrun is set. Ticks are never queued.
- If clear_overrun and a new overrun event occur in the same cycle, the set wins.
- Debounce:
  - stable_cnt (4 bits) and last_sample are updated only on CAPTURE.
  - If sample == last_sample, stable_cnt increments, saturating at DEBOUNCE_SAMPLES-1. Otherwise stable_cnt = 0.
  - last_sample takes the value of sample.
  - When stable_cnt reaches DEBOUNCE_SAMPLES-1 and sample ≠ level, level takes the value of sample.
  - The first sample after reset counts as 1 of DEBOUNCE_SAMPLES.
- press_pulse asserts for the single cycle after level goes 0→1. press_count increments in that same cycle.
- A release (1→0) produces no pulse.
- Reset values: read=0, address=0, level=0, press_pulse=0, press_count=0, overrun=0, FSM=IDLE, last_sample=0, stable_cnt=0, timer=POLL_DIV-1.
- If reset is asserted mid-read, read drops immediately (asynchronous) and the in-flight response is ignored.

## Timing
- Tick at cycle T: read=1 from cycle T+1.
- With waitrequest=0, the read is accepted at T+1. readdata is valid and captured at T+2. level/stable_cnt update at the T+2 edge, visible at T+3.
- press_pulse is visible in the same cycle as level's rise.
- Each waitrequest stall cycle adds 1 cycle of latency.
- Minimum press-to-level latency: DEBOUNCE_SAMPLES polls.
- read is a registered output. It deasserts in the cycle after acceptance and is never asserted two cycles back-to-back for one tick.

## Structure
- Package pio_poller_pkg contains:
  - the state enum (IDLE, REQ, CAPTURE);
  - PIO_DATA_ADDR = 2'd0;
  - the press_count width constant (8).
- Sub-module pio_debounce holds sample, last_sample, stable_cnt, level, press_pulse and press_count. Inputs: sample_valid, sample.
- The top-level holds the timer, FSM, Avalon signals and overrun.

## Test plan
- Reset with POLL_DIV=8, DEBOUNCE_SAMPLES=4 and the slave returning bit 0 = 1 (released, ACTIVE_LOW=1) → all outputs 0; read first asserts at cycle 8 after reset release; level stays 0 indefinitely.
- Slave bit 0 goes to 0 permanently → level rises after the 4th poll's capture; exactly one press_pulse; press_count=1.
- Bounce pattern 0,1,0,0,0,1 on successive polls → level never rises and press_count stays 0. Then 4 zeros → one press.
- waitrequest held high for 10 cycles with POLL_DIV=8 → read stays high and stable; overrun=1 after the dropped tick; clear_overrun returns it to 0. A simultaneous clear and overrun event leaves overrun=1.
- 256 clean presses → press_count wraps to 0 with 256 pulses. Reset asserted while read=1 → read=0 in the same cycle; the next read occurs POLL_DIV cycles after reset release.

Source files
------------

// File: rtl/pio_poller_pkg.sv
// Shared types and constants for the button-polling Avalon-MM master.
package pio_poller_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    CAPTURE = 2'd2
  } poll_state_e;

  localparam logic [1:0] PIO_DATA_ADDR = 2'd0;
  localparam int         PRESS_CNT_W   = 8;

endpackage

// File: rtl/pio_debounce.sv
// Debounces captured button samples into a level, a press strobe and a wrapping press count.
// The reset value of last_sample acts as a phantom "released" sample.
module pio_debounce
  import pio_poller_pkg::*;
#(
  parameter int DEBOUNCE_SAMPLES = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   sample_valid,
  input  logic                   sample,
  output logic                   level,
  output logic                   press_pulse,
  output logic [PRESS_CNT_W-1:0] press_count
);

  localparam logic [3:0] STABLE_MAX = 4'(DEBOUNCE_SAMPLES - 1);

  logic                   last_sample_q, last_sample_d;
  logic [3:0]             stable_cnt_q, stable_cnt_d;
  logic                   level_q, level_d;
  logic                   press_pulse_q, press_pulse_d;
  logic [PRESS_CNT_W-1:0] press_count_q, press_count_d;

  always_comb begin
    last_sample_d = last_sample_q;
    stable_cnt_d  = stable_cnt_q;
    level_d       = level_q;
    press_pulse_d = 1'b0;
    press_count_d = press_count_q;

    if (sample_valid) begin
      if (sample == last_sample_q) begin
        stable_cnt_d = (stable_cnt_q == STABLE_MAX) ? stable_cnt_q : stable_cnt_q + 4'd1;
      end else begin
        stable_cnt_d = 4'd0;
      end
      last_sample_d = sample;
      if ((stable_cnt_d == STABLE_MAX) && (sample != level_q)) begin
        level_d = sample;
      end
    end

    // Only a released->pressed edge counts as a press.
    if (level_d && !level_q) begin
      press_pulse_d = 1'b1;
      press_count_d = press_count_q + PRESS_CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_sample_q <= 1'b0;
      stable_cnt_q  <= 4'd0;
      level_q       <= 1'b0;
      press_pulse_q <= 1'b0;
      press_count_q <= '0;
    end else begin
      last_sample_q <= last_sample_d;
      stable_cnt_q  <= stable_cnt_d;
      level_q       <= level_d;
      press_pulse_q <= press_pulse_d;
      press_count_q <= press_count_d;
    end
  end

  assign level       = level_q;
  assign press_pulse = press_pulse_q;
  assign press_count = press_count_q;

endmodule

// File: rtl/pio_button_poller.sv
// Avalon-MM master polling bit 0 of a button PIO on a free-running tick and debouncing it.
// One read per tick; ticks arriving while a read is outstanding are dropped and flagged in overrun.
module pio_button_poller
  import pio_poller_pkg::*;
#(
  parameter int POLL_DIV         = 50000,
  parameter int DEBOUNCE_SAMPLES = 4,
  parameter int ACTIVE_LOW       = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  output logic [1:0]             address,
  output logic                   read,
  input  logic                   waitrequest,
  input  logic [31:0]            readdata,
  output logic                   level,
  output logic                   press_pulse,
  output logic [PRESS_CNT_W-1:0] press_count,
  output logic                   overrun,
  input  logic                   clear_overrun
);

  localparam int               TIMER_W      = $clog2(POLL_DIV);
  localparam logic [TIMER_W-1:0] TIMER_RELOAD = TIMER_W'(POLL_DIV - 1);
  localparam logic             INVERT       = (ACTIVE_LOW != 0) ? 1'b1 : 1'b0;

  logic [TIMER_W-1:0] timer_q, timer_d;
  poll_state_e        state_q, state_d;
  logic               read_q, read_d;
  logic               overrun_q, overrun_d;
  logic               tick;
  logic               sample_valid;
  logic               sample;
  logic               unused_rd_bits;

  assign tick = (timer_q == '0);

  always_comb begin
    timer_d   = tick ? TIMER_RELOAD : timer_q - TIMER_W'(1);
    state_d   = state_q;
    overrun_d = overrun_q;

    unique case (state_q)
      IDLE:    if (tick) state_d = REQ;
      REQ:     if (!waitrequest) state_d = CAPTURE;
      CAPTURE: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // A fresh overrun event beats a same-cycle clear.
    if (tick && (state_q != IDLE)) begin
      overrun_d = 1'b1;
    end else if (clear_overrun) begin
      overrun_d = 1'b0;
    end

    read_d = (state_d == REQ);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      timer_q   <= TIMER_RELOAD;
      state_q   <= IDLE;
      read_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      timer_q   <= timer_d;
      state_q   <= state_d;
      read_q    <= read_d;
      overrun_q <= overrun_d;
    end
  end

  // Read latency is 1, so readdata is valid during the CAPTURE cycle.
  assign sample_valid   = (state_q == CAPTURE);
  assign sample         = readdata[0] ^ INVERT;
  assign unused_rd_bits = ^readdata[31:1];

  pio_debounce #(
    .DEBOUNCE_SAMPLES(DEBOUNCE_SAMPLES)
  ) u_debounce (
    .clk         (clk),
    .rst         (reset),
    .sample_valid(sample_valid),
    .sample      (sample),
    .level       (level),
    .press_pulse (press_pulse),
    .press_count (press_count)
  );

  assign address = PIO_DATA_ADDR;
  assign read    = read_q;
  assign overrun = overrun_q;

endmodule
